mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port, variable-latency memory between the pipeline's instruction
//  fetch port (IF) and data-memory port (DM). Sits between the CPU core and memory in
//  top; arbitrates, sequences each access as a req/ack transaction and raises per-port
//  stall so the pipeline freezes until its access completes. DM has priority, with a
//  fairness counter so IF cannot be starved.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width
//  FAIR_LIMIT  4   consecutive DM grants while IF waits before IF is forced in (>=1)
//  TIMEOUT     16  cycles in ACCESS before forced completion (ARB_TIMEOUT_EN only)
// PORTS
//  clk_in     in   1   system clock, all state on rising edge
//  reset      in   1   asynchronous, active-low reset
//  if_req     in   1   IF access request, held until if_ack
//  if_addr    in   AW  IF address, stable while if_req
//  if_rdata   out  DW  IF read data, valid while if_ack
//  if_ack     out  1   IF completion, 1-cycle pulse
//  if_stall   out  1   if_req & ~if_ack (combinational)
//  dm_req     in   1   DM access request (DM_CS), held until dm_ack
//  dm_we      in   1   1=write (DM_W), 0=read (DM_R)
//  dm_addr    in   AW  DM address
//  dm_wdata   in   DW  DM write data
//  dm_rdata   out  DW  DM read data, valid while dm_ack (reads only)
//  dm_ack     out  1   DM completion, 1-cycle pulse
//  dm_stall   out  1   dm_req & ~dm_ack (combinational)
//  mem_cs     out  1   memory chip select, high for whole ACCESS
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, valid with mem_rdy
//  mem_rdy    in   1   memory completion, sampled only in ACCESS
//  err        out  1   1-cycle pulse with ack on timed-out access
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE; all outputs 0 (mem_*, acks, rdata, err);
//    fairness counter=0; grant owner=none. Reset mid-access abandons it, no ack issued.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE. All mem_*, acks, rdata, err registered.
//  - IDLE: sample reqs. DM only -> grant DM. IF only -> grant IF. Both: grant IF if
//    fair_cnt==FAIR_LIMIT, else DM. Grant latches addr/we/wdata into mem_* regs, next
//    state ACCESS. No req -> stay IDLE. IF access always mem_we=0.
//  - ACCESS: mem_cs=1, mem_* held constant. mem_rdy=1 -> capture mem_rdata into owner's
//    rdata reg (reads), drop mem_cs, go RESP. mem_rdy=0 -> stay.
//  - RESP: owner's ack=1 for exactly this cycle; reqs ignored; next state IDLE.
//    Requester must drop req at edge ending its ack cycle; a req still high in IDLE is
//    a new transaction.
//  - Min latency: req in IDLE cycle N, mem_cs at N+1, mem_rdy at N+1 -> ack at N+2.
//    Back-to-back transactions: one IDLE cycle between RESP and next ACCESS.
//  - fair_cnt: +1 (saturating at FAIR_LIMIT) on DM grant while if_req=1; cleared on
//    any IF grant and on DM grant with if_req=0.
//  - rdata regs hold last value outside ack; dm_rdata unchanged by writes.
//  - mem_rdy outside ACCESS ignored. Req changes during ACCESS/RESP do not affect the
//    in-flight transaction.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: ACCESS cycle counter; if mem_rdy not seen by TIMEOUT-th ACCESS
//    cycle, drop mem_cs, go RESP with owner's rdata=0 and err=1 with the ack.
//    mem_rdy on that same cycle wins (normal completion, err=0).
//  ARB_TIMEOUT_EN undefined: ACCESS waits indefinitely; err tied 0; no counter logic.
// TESTING
//  1 IF read 0x0000_0040, mem_rdy next cycle, mem_rdata=0x2008_0005 -> if_ack 2 cycles
//    after req, if_rdata=0x2008_0005, if_stall high until ack, dm_* untouched.
//  2 DM write addr 0x10 data 0xDEAD_BEEF with mem_rdy delayed 3 cycles -> mem_cs/we high
//    4 cycles, mem_wdata stable, single dm_ack pulse, dm_stall high throughout.
//  3 if_req and dm_req same cycle -> DM served first, IF second; exactly one ack each.
//  4 dm_req re-asserted continuously with if_req held, FAIR_LIMIT=4 -> 4 DM grants
//    then 1 IF grant, then DM resumes; fair_cnt back to 0.
//  5 reset low during ACCESS with mem_rdy never asserted -> all outputs 0 immediately,
//    state IDLE, no ack after reset release until new req.
//  6 ARB_TIMEOUT_EN, TIMEOUT=16, mem_rdy stuck 0 on DM read -> dm_ack+err after 16
//    ACCESS cycles, dm_rdata=0; without macro, stall persists, err stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: IF and DM request ports on the core side,
// single-port memory request on the other.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          if_stall;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          dm_stall;
  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdy;
  logic          err;

  // Arbiter side
  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_rdy,
    output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
    output mem_cs, mem_we, mem_addr, mem_wdata, err
  );

  // Core and memory side
  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_rdy,
    input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
    input  mem_cs, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency single-port memory between IF and DM with DM priority
// and an IF fairness counter. Optional access timeout under `ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter  int AW         = 32,
  parameter  int DW         = 32,
  parameter  int FAIR_LIMIT = 4,
  parameter  int TIMEOUT    = 16,
  localparam int FW         = $clog2(FAIR_LIMIT + 1)
) (
  input  logic              clk_in,
  input  logic              reset,
  mem_port_arbiter_if.master bus,
  output logic [1:0]        state_dbg,
  output logic [FW-1:0]     fair_cnt_dbg
);

  // Handshake: a requester raises req and holds req/addr/data stable until it sees
  // a one-cycle ack, then drops req at the edge ending that ack cycle; req still
  // high in IDLE starts a new transaction. Memory: mem_cs held for the whole access,
  // mem_rdy (sampled only during ACCESS) completes it with mem_rdata.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_DM = 2'd2} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic          grant_if, grant_dm, done, tmo_hit;
  logic [FW-1:0] fair_q;
  logic          mem_cs_q, mem_we_q, if_ack_q, dm_ack_q, err_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q;

  // Last allowed ACCESS cycle without mem_rdy; a same-cycle mem_rdy completes normally.
  assign tmo_hit = (state_q == ACCESS) && (tmo_cnt_q == TW'(TIMEOUT - 1)) && !bus.mem_rdy;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)                tmo_cnt_q <= '0;
    else if (state_q == ACCESS) tmo_cnt_q <= tmo_cnt_q + 1'b1;
    else                       tmo_cnt_q <= '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dm_req && (!bus.if_req || fair_q != FW'(FAIR_LIMIT))) grant_dm = 1'b1;
        else if (bus.if_req)                                            grant_if = 1'b1;
        if (grant_dm) begin
          state_d = ACCESS;
          owner_d = OWN_DM;
        end else if (grant_if) begin
          state_d = ACCESS;
          owner_d = OWN_IF;
        end
      end
      ACCESS: begin
        done = bus.mem_rdy || tmo_hit;
        if (done) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      fair_q      <= '0;
    end else begin
      if_ack_q <= done && (owner_q == OWN_IF);
      dm_ack_q <= done && (owner_q == OWN_DM);
      err_q    <= tmo_hit;
      if (grant_dm) begin
        mem_cs_q    <= 1'b1;
        mem_we_q    <= bus.dm_we;
        mem_addr_q  <= bus.dm_addr;
        mem_wdata_q <= bus.dm_wdata;
      end else if (grant_if) begin
        mem_cs_q   <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= bus.if_addr;
      end else if (done) begin
        mem_cs_q <= 1'b0;
        mem_we_q <= 1'b0;
      end
      if (done && owner_q == OWN_IF)
        if_rdata_q <= tmo_hit ? '0 : bus.mem_rdata;
      if (done && owner_q == OWN_DM && !mem_we_q)
        dm_rdata_q <= tmo_hit ? '0 : bus.mem_rdata;
      // Count DM wins only while IF is actually waiting.
      if (grant_if)
        fair_q <= '0;
      else if (grant_dm)
        fair_q <= !bus.if_req ? '0 : (fair_q == FW'(FAIR_LIMIT)) ? fair_q : fair_q + 1'b1;
    end
  end

  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.err       = err_q;
  assign bus.if_stall  = bus.if_req & ~if_ack_q;
  assign bus.dm_stall  = bus.dm_req & ~dm_ack_q;
  assign state_dbg     = state_q;
  assign fair_cnt_dbg  = fair_q;

endmodule
